mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of a 5-stage in-order pipeline.
//
// Captures an instruction from EXE, waits for data-memory load data when the
// instruction is a load, shapes the data (LW/LB/LBU/LH/LHU, LWL/LWR merge with
// the old rt value) and presents the write-back value to WB with a
// valid/allowin handshake on both sides.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   exe_valid_in / mem_allowin_out    EXE -> MEM handshake
//   mem_valid_out / wb_allowin_in     MEM -> WB handshake
//   exe_alures_in                 ALU result / data address
//   exe_rt_in                     old rt value for LWL/LWR merge
//   exe_sel_wbdata_in             one-hot write-back source select
//   exe_lubhw_con_in              one-hot LW/LB/LBU/LH/LHU select
//   exe_onehot_in                 [7:4] LWL byte n, [3:0] LWR byte n
//   exe_PC_in, exe_NNPC_in        PC and PC+8 (link value)
//   exe_wnum_in, exe_write_type_in    destination register and write type
//   dm_rvalid_in, dm_rdata_in     load data return from data memory
//   mem_wbdata_out                final write-back value
//   mem_wnum_out, mem_write_type_out  destination, zero when stage empty
//   mem_PC_out                    PC of the held instruction
//
// Build option MEM_FWD_EN: adds mem_fwd_wnum_out / mem_fwd_ok_out for an ID
// stage bypass that uses mem_wbdata_out as the forwarded value.
//
// FSM states:
//   state  | meaning
//   IDLE   | no load outstanding (empty, or holding a non-load)
//   WAIT   | load captured, data not yet returned
//   DONE   | load data buffered, waiting for WB handoff

module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid_in,
  output logic        mem_allowin_out,
  input  logic        wb_allowin_in,
  output logic        mem_valid_out,
  input  logic [31:0] exe_alures_in,
  input  logic [31:0] exe_rt_in,
  input  logic [3:0]  exe_sel_wbdata_in,
  input  logic [4:0]  exe_lubhw_con_in,
  input  logic [7:0]  exe_onehot_in,
  input  logic [31:0] exe_PC_in,
  input  logic [31:0] exe_NNPC_in,
  input  logic [4:0]  exe_wnum_in,
  input  logic [2:0]  exe_write_type_in,
  input  logic        dm_rvalid_in,
  input  logic [31:0] dm_rdata_in,
  output logic [31:0] mem_wbdata_out,
  output logic [4:0]  mem_wnum_out,
  output logic [2:0]  mem_write_type_out,
  output logic [31:0] mem_PC_out
`ifdef MEM_FWD_EN
  ,
  output logic [4:0]  mem_fwd_wnum_out,
  output logic        mem_fwd_ok_out
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_r, state_nxt;
  logic        valid_r;
  logic [31:0] alures_r, rt_r, pc_r, nnpc_r, rdata_r;
  logic [3:0]  sel_r;
  logic [4:0]  con_r;
  logic [7:0]  onehot_r;
  logic [4:0]  wnum_r;
  logic [2:0]  wtype_r;

  logic is_load, exe_is_load, ready, capture, handoff, rdata_take;
  logic [31:0] byte_ext, half_ext, lubhw_val, llr_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign is_load     = sel_r[1] | sel_r[2];
  assign exe_is_load = exe_sel_wbdata_in[1] | exe_sel_wbdata_in[2];
  assign ready       = !is_load || (state_r == S_DONE);

  assign mem_valid_out   = valid_r && ready;
  assign mem_allowin_out = !valid_r || (ready && wb_allowin_in);

  assign capture = mem_allowin_out && exe_valid_in;
  assign handoff = mem_valid_out && wb_allowin_in;

  // Load data is taken while waiting, or in the very cycle a load is captured
  // (the response then belongs to the load entering the stage). Any other
  // dm_rvalid_in is stray and must not disturb the buffered word.
  assign rdata_take = dm_rvalid_in &&
                      ((state_r == S_WAIT) || (capture && exe_is_load));

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_WAIT:  if (dm_rvalid_in) state_nxt = S_DONE;
      S_DONE:  if (handoff) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (capture) begin
      if (exe_is_load) state_nxt = dm_rvalid_in ? S_DONE : S_WAIT;
      else             state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      valid_r  <= 1'b0;
      alures_r <= '0;
      rt_r     <= '0;
      sel_r    <= '0;
      con_r    <= '0;
      onehot_r <= '0;
      pc_r     <= '0;
      nnpc_r   <= '0;
      wnum_r   <= '0;
      wtype_r  <= '0;
      rdata_r  <= '0;
    end else begin
      state_r <= state_nxt;
      if (mem_allowin_out) valid_r <= exe_valid_in;
      if (capture) begin
        alures_r <= exe_alures_in;
        rt_r     <= exe_rt_in;
        sel_r    <= exe_sel_wbdata_in;
        con_r    <= exe_lubhw_con_in;
        onehot_r <= exe_onehot_in;
        pc_r     <= exe_PC_in;
        nnpc_r   <= exe_NNPC_in;
        wnum_r   <= exe_wnum_in;
        wtype_r  <= exe_write_type_in;
      end
      if (rdata_take) rdata_r <= dm_rdata_in;
    end
  end

  // Little-endian byte/halfword pick by address.
  always_comb begin
    case (alures_r[1:0])
      2'd0:    ld_byte = rdata_r[7:0];
      2'd1:    ld_byte = rdata_r[15:8];
      2'd2:    ld_byte = rdata_r[23:16];
      default: ld_byte = rdata_r[31:24];
    endcase
    ld_half  = alures_r[1] ? rdata_r[31:16] : rdata_r[15:0];
    byte_ext = {{24{con_r[1] & ld_byte[7]}}, ld_byte};
    half_ext = {{16{con_r[3] & ld_half[15]}}, ld_half};
  end

  always_comb begin
    lubhw_val = '0;
    if (con_r[0])                 lubhw_val = rdata_r;
    else if (con_r[1] | con_r[2]) lubhw_val = byte_ext;
    else if (con_r[3] | con_r[4]) lubhw_val = half_ext;
  end

  // LWL n keeps the low (3-n) bytes of rt and fills the rest from memory
  // shifted up; LWR n keeps the high n bytes of rt.
  always_comb begin
    llr_val = '0;
    for (int n = 0; n < 4; n++) begin
      if (onehot_r[n])
        llr_val = (rdata_r >> (8 * n)) | (rt_r & ~(32'hFFFF_FFFF >> (8 * n)));
      if (onehot_r[n + 4])
        llr_val = (rdata_r << (8 * (3 - n))) |
                  (rt_r & ~(32'hFFFF_FFFF << (8 * (3 - n))));
    end
  end

  always_comb begin
    mem_wbdata_out = '0;
    if (sel_r[0])      mem_wbdata_out = alures_r;
    else if (sel_r[1]) mem_wbdata_out = lubhw_val;
    else if (sel_r[2]) mem_wbdata_out = llr_val;
    else if (sel_r[3]) mem_wbdata_out = nnpc_r;
  end

  assign mem_wnum_out       = valid_r ? wnum_r : 5'd0;
  assign mem_write_type_out = valid_r ? wtype_r : 3'd0;
  assign mem_PC_out         = pc_r;

`ifdef MEM_FWD_EN
  assign mem_fwd_wnum_out = valid_r ? wnum_r : 5'd0;
  assign mem_fwd_ok_out   = mem_valid_out;
`else
  // No bypass outputs in this build.
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid, mem_allowin, wb_allowin, mem_valid;
  logic [31:0] e_alu, e_rt, e_pc, e_nnpc;
  logic [3:0]  e_sel;
  logic [4:0]  e_con;
  logic [7:0]  e_oh;
  logic [4:0]  e_wnum;
  logic [2:0]  e_wt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] wbdata, mem_pc;
  logic [4:0]  mem_wnum;
  logic [2:0]  mem_wt;
`ifdef MEM_FWD_EN
  logic [4:0]  fwd_wnum;
  logic        fwd_ok;
`endif

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .exe_valid_in(exe_valid), .mem_allowin_out(mem_allowin),
    .wb_allowin_in(wb_allowin), .mem_valid_out(mem_valid),
    .exe_alures_in(e_alu), .exe_rt_in(e_rt),
    .exe_sel_wbdata_in(e_sel), .exe_lubhw_con_in(e_con),
    .exe_onehot_in(e_oh), .exe_PC_in(e_pc), .exe_NNPC_in(e_nnpc),
    .exe_wnum_in(e_wnum), .exe_write_type_in(e_wt),
    .dm_rvalid_in(rvalid), .dm_rdata_in(rdata),
    .mem_wbdata_out(wbdata), .mem_wnum_out(mem_wnum),
    .mem_write_type_out(mem_wt), .mem_PC_out(mem_pc)
`ifdef MEM_FWD_EN
    , .mem_fwd_wnum_out(fwd_wnum), .mem_fwd_ok_out(fwd_ok)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: one slot holding the instruction in MEM.
  logic        m_occ, m_done;
  logic [3:0]  m_sel;
  logic [4:0]  m_con;
  logic [7:0]  m_oh;
  logic [31:0] m_alu, m_rt, m_pc, m_nnpc, m_mem;
  logic [4:0]  m_wnum;
  logic [2:0]  m_wt;
  int          rv_cnt;

  function automatic logic m_load();
    return (m_sel == 4'b0010) || (m_sel == 4'b0100);
  endfunction

  function automatic logic [31:0] model_wb();
    logic [31:0] b, h, r;
    int a;
    a = int'(m_alu[1:0]);
    b = (m_mem >> (8 * a)) & 32'hFF;
    h = m_alu[1] ? (m_mem >> 16) : (m_mem & 32'hFFFF);
    r = 32'd0;
    if (m_sel == 4'b0001) r = m_alu;
    else if (m_sel == 4'b1000) r = m_nnpc;
    else if (m_sel == 4'b0010) begin
      if (m_con == 5'b00001)      r = m_mem;
      else if (m_con == 5'b00010) r = (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      else if (m_con == 5'b00100) r = b;
      else if (m_con == 5'b01000) r = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      else if (m_con == 5'b10000) r = h;
    end else if (m_sel == 4'b0100) begin
      for (int n = 0; n < 4; n++) begin
        if (m_oh == (8'h10 << n))
          r = (m_mem << (8 * (3 - n))) | (m_rt & ~(32'hFFFF_FFFF << (8 * (3 - n))));
        if (m_oh == (8'h01 << n))
          r = (m_mem >> (8 * n)) | (m_rt & ~(32'hFFFF_FFFF >> (8 * n)));
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_occ = 0; m_done = 0; m_sel = 0; m_con = 0; m_oh = 0;
    m_alu = 0; m_rt = 0; m_pc = 0; m_nnpc = 0; m_mem = 0;
    m_wnum = 0; m_wt = 0; rv_cnt = 0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    logic rdy, allow, cap, hand;
    #1;
    rdy   = m_occ && (!m_load() || m_done);
    allow = !m_occ || (rdy && wb_allowin);
    check_val("valid", {31'd0, mem_valid}, {31'd0, rdy});
    check_val("allowin", {31'd0, mem_allowin}, {31'd0, allow});
    if (rdy) begin
      check_val("wbdata", wbdata, model_wb());
      check_val("wnum", {27'd0, mem_wnum}, {27'd0, m_wnum});
      check_val("wtype", {29'd0, mem_wt}, {29'd0, m_wt});
      check_val("pc", mem_pc, m_pc);
    end
    if (!m_occ) begin
      check_val("wnum_mask", {27'd0, mem_wnum}, 32'd0);
      check_val("wtype_mask", {29'd0, mem_wt}, 32'd0);
    end
`ifdef MEM_FWD_EN
    check_val("fwd_ok", {31'd0, fwd_ok}, {31'd0, rdy});
    check_val("fwd_wnum", {27'd0, fwd_wnum}, m_occ ? {27'd0, m_wnum} : 32'd0);
`endif
    cap  = allow && exe_valid;
    hand = rdy && wb_allowin;
    @(posedge clk);
    if (m_occ && m_load() && !m_done && rvalid) begin
      m_done = 1; m_mem = rdata;
    end
    if (m_occ && m_load() && !m_done && rv_cnt > 0) rv_cnt--;
    if (cap) begin
      m_occ = 1; m_done = 0; m_sel = e_sel; m_con = e_con; m_oh = e_oh;
      m_alu = e_alu; m_rt = e_rt; m_pc = e_pc; m_nnpc = e_nnpc;
      m_wnum = e_wnum; m_wt = e_wt;
      rv_cnt = $urandom_range(1, 4);
    end else if (hand) begin
      m_occ = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [3:0] sel, input logic [4:0] con,
                           input logic [7:0] oh, input logic [31:0] alu,
                           input logic [31:0] rt);
    e_sel = sel; e_con = con; e_oh = oh; e_alu = alu; e_rt = rt;
    e_pc = $urandom; e_nnpc = e_pc + 32'd8;
    e_wnum = 5'($urandom); e_wt = 3'($urandom);
  endtask

  task automatic rand_instr();
    int k, n;
    k = $urandom_range(0, 5);
    case (k)
      0: set_instr(4'b0001, 5'd0, 8'd0, $urandom, $urandom);
      1: set_instr(4'b1000, 5'd0, 8'd0, $urandom, $urandom);
      2: set_instr(4'b0000, 5'd0, 8'd0, $urandom, $urandom);
      3, 4: set_instr(4'b0010, 5'b00001 << $urandom_range(0, 4), 8'd0, $urandom, $urandom);
      default: begin
        n = $urandom_range(0, 3);
        set_instr(4'b0100, 5'd0,
                  ($urandom_range(0, 1) == 1) ? (8'h10 << n) : (8'h01 << n),
                  $urandom, $urandom);
        e_alu[1:0] = 2'(n);
      end
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, {31'd0, mem_valid}, 32'd0);
    check_val({tag, "_allowin"}, {31'd0, mem_allowin}, 32'd1);
    check_val({tag, "_wbdata"}, wbdata, 32'd0);
    check_val({tag, "_wnum"}, {27'd0, mem_wnum}, 32'd0);
    check_val({tag, "_wtype"}, {29'd0, mem_wt}, 32'd0);
    check_val({tag, "_pc"}, mem_pc, 32'd0);
  endtask

  initial begin
    rst = 1; exe_valid = 0; wb_allowin = 1; rvalid = 0; rdata = 0;
    set_instr(4'd0, 5'd0, 8'd0, 32'd0, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;
    @(negedge clk);

    // ADD: one-cycle latency
    set_instr(4'b0001, 5'd0, 8'd0, 32'h0000_1234, 32'd0);
    exe_valid = 1; wb_allowin = 1;
    cycle();
    exe_valid = 0;
    check_val("add_valid", {31'd0, mem_valid}, 32'd1);
    check_val("add_wbdata", wbdata, 32'h0000_1234);
    cycle();

    // LB at byte 2, data three cycles later, then WB stalls for four cycles
    set_instr(4'b0010, 5'b00010, 8'd0, 32'h1000_0002, 32'd0);
    exe_valid = 1;
    cycle();
    exe_valid = 0;
    cycle();
    check_val("lb_wait1", {31'd0, mem_valid}, 32'd0);
    cycle();
    check_val("lb_wait2", {31'd0, mem_valid}, 32'd0);
    rvalid = 1; rdata = 32'h1180_2233;
    cycle();
    rvalid = 0; rdata = 32'hDEAD_BEEF;
    check_val("lb_valid", {31'd0, mem_valid}, 32'd1);
    check_val("lb_wbdata", wbdata, 32'hFFFF_FF80);
    wb_allowin = 0;
    set_instr(4'b0001, 5'd0, 8'd0, 32'h0000_5678, 32'd0);
    exe_valid = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_val("stall_wbdata", wbdata, 32'hFFFF_FF80);
      check_val("stall_allowin", {31'd0, mem_allowin}, 32'd0);
    end
    wb_allowin = 1;
    cycle();
    exe_valid = 0;
    check_val("after_stall", wbdata, 32'h0000_5678);
    cycle();

    // LWL / LWR with n = 1
    set_instr(4'b0100, 5'd0, 8'b0010_0000, 32'h2000_0001, 32'h1122_3344);
    exe_valid = 1;
    cycle();
    exe_valid = 0; rvalid = 1; rdata = 32'hAABB_CCDD;
    cycle();
    rvalid = 0;
    check_val("lwl1", wbdata, 32'hCCDD_3344);
    cycle();
    set_instr(4'b0100, 5'd0, 8'b0000_0010, 32'h2000_0001, 32'h1122_3344);
    exe_valid = 1;
    cycle();
    exe_valid = 0; rvalid = 1; rdata = 32'hAABB_CCDD;
    cycle();
    rvalid = 0;
    check_val("lwr1", wbdata, 32'h11AA_BBCC);
    cycle();

    // reset in the middle of a load wait, then a stray response
    set_instr(4'b0010, 5'b00001, 8'd0, 32'h3000_0000, 32'd0);
    exe_valid = 1;
    cycle();
    exe_valid = 0;
    cycle();
    rst = 1;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 0; rvalid = 1; rdata = 32'h5555_AAAA;
    cycle();
    cycle();
    rvalid = 0;
    check_val("stray_valid", {31'd0, mem_valid}, 32'd0);
    set_instr(4'b0001, 5'd0, 8'd0, 32'h0BAD_F00D, 32'd0);
    exe_valid = 1;
    cycle();
    exe_valid = 0;
    check_val("post_rst_add", wbdata, 32'h0BAD_F00D);
    cycle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      wb_allowin = ($urandom_range(0, 3) != 0);
      exe_valid  = ($urandom_range(0, 3) != 0);
      rand_instr();
      rdata = $urandom;
      if (m_occ && m_load() && !m_done)
        rvalid = (rv_cnt == 1);
      else
        rvalid = !(exe_valid && (e_sel[1] || e_sel[2])) && ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
